// File: rtl/icache_pkg.sv
// Shared types and constants for the instruction-cache refill path.
package icache_pkg;

    localparam int LINE_ADDR_W    = 8;
    localparam int WORD_ADDR_W    = 10;
    localparam int WORDS_PER_LINE = 4;
    localparam int BEAT_W         = 2;
    localparam int WORD_W         = 32;
    localparam logic [WORD_W-1:0] RV_NOP = 32'h0000_0013;

    // Refill sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2,
        S_HOLD  = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_refill_wdog.sv
// Per-beat watchdog: counts consecutive enabled cycles and flags expiry on
// the TIMEOUT_CYC-th one, so the owner can abort in that same cycle.
module icache_refill_wdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT_CYC) + 1;

    logic [CW-1:0] r_cnt;

    assign o_expire = i_enable && (r_cnt == CW'(TIMEOUT_CYC - 1));

    // Count stalled cycles; restart on clear or once expiry has been reported
    always_ff @(posedge clk) begin
        if (reset || i_clear || o_expire) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/icache_refill_unit.sv
// I-cache line refill: fetches four 32-bit words from instruction memory,
// assembles them into one 128-bit line and handshakes completion with the
// cache controller. A stalled beat is abandoned after TIMEOUT_CYC cycles and
// the rest of the line is padded with NOPs.
module icache_refill_unit
    import icache_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                mem_req_i,
    input  logic [LINE_ADDR_W-1:0]              addr_mem_i,
    output logic                                mem_comp_o,
    output logic [WORDS_PER_LINE*WORD_W-1:0]    mem_data_o,
    output logic                                refill_err_o,
    output logic                                busy_o,
    output logic                                bus_req_o,
    output logic [WORD_ADDR_W-1:0]              bus_addr_o,
    input  logic                                bus_ack_i,
    input  logic [WORD_W-1:0]                   bus_rdata_i
);

    refill_state_e                              r_state;
    logic [LINE_ADDR_W-1:0]                     r_line;
    logic [BEAT_W-1:0]                          r_beat;
    logic [WORDS_PER_LINE-1:0][WORD_W-1:0]      r_line_buf;
    logic                                       r_bus_req;
    logic                                       r_comp;
    logic                                       r_err;

    logic w_fetch;
    logic w_wd_en;
    logic w_wd_clr;
    logic w_expire;

    // Watchdog only runs while a beat is outstanding and unanswered
    assign w_fetch  = (r_state == S_FETCH);
    assign w_wd_en  = w_fetch && !bus_ack_i;
    assign w_wd_clr = !w_fetch || bus_ack_i;

    icache_refill_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_wd_clr),
        .i_enable (w_wd_en),
        .o_expire (w_expire)
    );

    assign mem_data_o   = r_line_buf;
    assign mem_comp_o   = r_comp;
    assign refill_err_o = r_err;
    assign bus_req_o    = r_bus_req;
    assign bus_addr_o   = {r_line, r_beat};
    assign busy_o       = (r_state != S_IDLE);

    // Refill sequencer with registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_line     <= '0;
            r_beat     <= '0;
            r_line_buf <= '0;
            r_bus_req  <= 1'b0;
            r_comp     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_comp <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mem_req_i) begin
                        r_state   <= S_FETCH;
                        r_line    <= addr_mem_i;
                        r_beat    <= '0;
                        r_bus_req <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (bus_ack_i) begin
                        r_line_buf[r_beat] <= bus_rdata_i;
                        r_beat             <= r_beat + 2'd1;
                        if (r_beat == BEAT_W'(WORDS_PER_LINE - 1)) begin
                            r_state   <= S_DONE;
                            r_bus_req <= 1'b0;
                            r_comp    <= 1'b1;
                        end
                    end else if (w_expire) begin
                        // Abandon the line: pad the stalled beat and all later ones
                        for (int k = 0; k < WORDS_PER_LINE; k++) begin
                            if (BEAT_W'(k) >= r_beat) begin
                                r_line_buf[k] <= RV_NOP;
                            end
                        end
                        r_beat    <= '0;
                        r_state   <= S_DONE;
                        r_bus_req <= 1'b0;
                        r_comp    <= 1'b1;
                        r_err     <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_HOLD;
                end
                S_HOLD: begin
                    // Wait for the controller to drop its level request
                    if (!mem_req_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit: a line-level reference model checked
// every cycle, plus hand-computed expectations for each scenario.
module tb_icache_refill_unit;

    localparam int TMO = 8;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk;
    logic         reset;
    logic         mem_req_i;
    logic [7:0]   addr_mem_i;
    logic         mem_comp_o;
    logic [127:0] mem_data_o;
    logic         refill_err_o;
    logic         busy_o;
    logic         bus_req_o;
    logic [9:0]   bus_addr_o;
    logic         bus_ack_i;
    logic [31:0]  bus_rdata_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit chk_en = 0;

    icache_refill_unit #(.TIMEOUT_CYC(TMO)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req_i    (mem_req_i),
        .addr_mem_i   (addr_mem_i),
        .mem_comp_o   (mem_comp_o),
        .mem_data_o   (mem_data_o),
        .refill_err_o (refill_err_o),
        .busy_o       (busy_o),
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: phase 0 idle, 1 fetching, 2 completing, 3 waiting for release
    int           m_st;
    logic [7:0]   m_line;
    int           m_beat;
    int           m_stall;
    logic [127:0] m_data;
    logic         m_comp;
    logic         m_err;
    bit           m_clean;

    always @(posedge clk) begin
        if (reset) begin
            m_st <= 0; m_line <= '0; m_beat <= 0; m_stall <= 0;
            m_data <= '0; m_comp <= 1'b0; m_err <= 1'b0; m_clean <= 1'b1;
        end else begin
            m_comp <= 1'b0;
            m_err  <= 1'b0;
            if (m_st == 0) begin
                if (mem_req_i) begin
                    m_st <= 1; m_line <= addr_mem_i; m_beat <= 0;
                    m_stall <= 0; m_clean <= 1'b0;
                end
            end else if (m_st == 1) begin
                if (bus_ack_i) begin
                    m_data[32*m_beat +: 32] <= bus_rdata_i;
                    m_stall <= 0;
                    if (m_beat == 3) begin
                        m_st <= 2; m_comp <= 1'b1;
                    end else begin
                        m_beat <= m_beat + 1;
                    end
                end else if (m_stall + 1 == TMO) begin
                    for (int k = 0; k < 4; k++)
                        if (k >= m_beat) m_data[32*k +: 32] <= NOP;
                    m_st <= 2; m_comp <= 1'b1; m_err <= 1'b1; m_stall <= 0;
                end else begin
                    m_stall <= m_stall + 1;
                end
            end else if (m_st == 2) begin
                m_st <= 3;
            end else begin
                if (!mem_req_i) m_st <= 0;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy_o, m_st != 0);
            chk("bus_req", bus_req_o, m_st == 1);
            chk("comp", mem_comp_o, m_comp);
            chk("err", refill_err_o, m_err);
            chk("data", mem_data_o, m_data);
            if (m_st == 1 || m_clean)
                chk("bus_addr", bus_addr_o, {m_line, 2'(m_beat)});
        end
    end

    // One refill. sbeat/scyc: beat that stalls and for how long (scyc<0: never acked).
    // lat: the cycle ending at edge N+lat carries mem_comp_o, N = request sampling edge.
    task automatic refill(input logic [7:0] a, input logic [127:0] d, input int sbeat,
                          input int scyc, input bit drop_early, input int hold_extra,
                          output int lat, output logic [127:0] line, output logic err);
        int n_edge;
        int k;
        bit tmo;
        mem_req_i = 1'b1; addr_mem_i = a; bus_ack_i = 1'b0;
        @(posedge clk); #2;
        n_edge = cyc;
        addr_mem_i = ~a;
        if (drop_early) mem_req_i = 1'b0;
        tmo = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == sbeat) begin
                for (int s = 0; s < ((scyc < 0) ? TMO : scyc); s++) begin
                    chk("addr_stall", bus_addr_o, {a, 2'(b)});
                    bus_ack_i = 1'b0;
                    @(posedge clk); #2;
                end
                if (scyc < 0) tmo = 1'b1;
            end
            if (tmo) break;
            chk("addr_beat", bus_addr_o, {a, 2'(b)});
            bus_ack_i = 1'b1; bus_rdata_i = d[32*b +: 32];
            @(posedge clk); #2;
        end
        bus_ack_i = 1'b0; bus_rdata_i = $urandom;
        k = 0;
        while (!mem_comp_o && k < 20) begin
            @(posedge clk); #2;
            k++;
        end
        chk("comp_seen", mem_comp_o, 1'b1);
        lat = cyc - n_edge + 1;
        line = mem_data_o;
        err = refill_err_o;
        // Stray acks while holding must not touch the line
        for (int h = 0; h < 1 + hold_extra; h++) begin
            bus_ack_i = (h > 0); bus_rdata_i = $urandom;
            @(posedge clk); #2;
        end
        bus_ack_i = 1'b0;
        chk("hold_busy", busy_o, 1'b1);
        chk("hold_noreq", bus_req_o, 1'b0);
        mem_req_i = 1'b0;
        @(posedge clk); #2;
        chk("release_busy", busy_o, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [127:0] line;
        logic err;

        reset = 1'b1; mem_req_i = 1'b0; addr_mem_i = '0;
        bus_ack_i = 1'b0; bus_rdata_i = '0;
        @(posedge clk); #2;
        chk_en = 1'b1;
        @(posedge clk); #2;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_bus_req", bus_req_o, 1'b0);
        chk("rst_addr", bus_addr_o, 10'h000);
        chk("rst_data", mem_data_o, 128'h0);
        reset = 1'b0;
        @(posedge clk); #2;

        // Zero-wait line at 0xA5: words at 0x294..0x297
        refill(8'hA5, 128'h00000044_00000033_00000022_00000011, 4, 0, 1'b0, 0, lat, line, err);
        chk("lat_zero_wait", lat, 5);
        chk("line_a5", line, 128'h00000044_00000033_00000022_00000011);
        chk("err_a5", err, 1'b0);

        // Beat 2 acked after a 3-cycle stall
        refill(8'h3C, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 2, 3, 1'b0, 0, lat, line, err);
        chk("lat_stall3", lat, 8);
        chk("line_3c", line, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0);

        // Beat 1 never acked: 1 ack + 8 stalled cycles, then completion with error
        refill(8'h5A, 128'h44444444_33333333_22222222_A1B2C3D4, 1, -1, 1'b0, 0, lat, line, err);
        chk("lat_timeout", lat, 10);
        chk("line_timeout", line, 128'h00000013_00000013_00000013_A1B2C3D4);
        chk("err_timeout", err, 1'b1);

        // Request held 4 cycles past completion: one refill only
        refill(8'h11, 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA, 4, 0, 1'b0, 3, lat, line, err);
        chk("lat_hold", lat, 5);
        chk("line_hold", line, 128'h0F0F0F0F_F0F0F0F0_55555555_AAAAAAAA);

        // Request dropped during fetch: line still completes
        refill(8'h77, 128'h13572468_24681357_FEDCBA98_01234567, 0, 2, 1'b1, 0, lat, line, err);
        chk("lat_drop", lat, 7);
        chk("line_drop", line, 128'h13572468_24681357_FEDCBA98_01234567);

        // Reset while beat 2 is outstanding, with an ack arriving at/after reset
        mem_req_i = 1'b1; addr_mem_i = 8'hC3;
        @(posedge clk); #2;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
        @(posedge clk); #2;
        bus_rdata_i = 32'h3333_4444;
        @(posedge clk); #2;
        chk("pre_rst_addr", bus_addr_o, {8'hC3, 2'd2});
        reset = 1'b1; bus_rdata_i = 32'h5555_6666;
        @(posedge clk); #2;
        chk("rst_mid_bus_req", bus_req_o, 1'b0);
        chk("rst_mid_busy", busy_o, 1'b0);
        chk("rst_mid_data", mem_data_o, 128'h0);
        reset = 1'b0; mem_req_i = 1'b0;
        @(posedge clk); #2;
        bus_ack_i = 1'b0;
        chk("late_ack_data", mem_data_o, 128'h0);
        refill(8'hC3, 128'h89ABCDEF_76543210_00FF00FF_FF00FF00, 4, 0, 1'b0, 0, lat, line, err);
        chk("lat_after_rst", lat, 5);
        chk("line_after_rst", line, 128'h89ABCDEF_76543210_00FF00FF_FF00FF00);

        repeat (2) @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icache_refill_unit.md
ICACHE_REFILL_UNIT -- requirements
Module: icache_refill_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, max cycles one bus beat may wait for bus_ack_i before abort.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_req_i  input  1  level refill request from I-cache controller; held high until after mem_comp_o.
REQ-005 addr_mem_i  input  8  line address {tag[25:20], set_id}; valid when mem_req_i first seen high.
REQ-006 mem_comp_o  output  1  one-cycle pulse: 128-bit line on mem_data_o is valid.
REQ-007 mem_data_o  output  128  assembled line; word k at bits [32k+31:32k].
REQ-008 refill_err_o  output  1  one-cycle pulse coincident with mem_comp_o when a beat timed out.
REQ-009 busy_o  output  1  high in every state except IDLE.
REQ-010 bus_req_o  output  1  word-read request to instruction memory.
REQ-011 bus_addr_o  output  10  word address {line address, beat[1:0]}.
REQ-012 bus_ack_i  input  1  memory accepted and returned a word this cycle.
REQ-013 bus_rdata_i  input  32  read word, valid when bus_ack_i high.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, DONE and HOLD.
REQ-015 IDLE -> FETCH when mem_req_i=1; addr_mem_i captured into line register, beat counter set to 0, line buffer unchanged.
REQ-016 In FETCH: bus_req_o=1, bus_addr_o={line register, beat}; address stable until bus_ack_i.
REQ-017 On bus_ack_i in FETCH: bus_rdata_i written to word slot [beat], beat increments, watchdog cleared; bus_req_o stays high for the next beat (back-to-back acks allowed).
REQ-018 Ack on beat 3 -> DONE; bus_req_o low from the following cycle.
REQ-019 DONE lasts one cycle: mem_comp_o=1; then -> HOLD.
REQ-020 HOLD -> IDLE when mem_req_i=0; a request still high in HOLD SHALL NOT start a new refill.
REQ-021 mem_data_o SHALL hold its value from DONE until the next ack writes a slot.
REQ-022 Latency with zero-wait memory: mem_req_i sampled at edge N -> acks at cycles N+1..N+4 -> mem_comp_o high in cycle N+5; minimum is 5 cycles and never less.
REQ-023 Watchdog counts FETCH cycles without ack; at count TIMEOUT_CYC, remaining slots (current and later beats) SHALL be filled with 32'h0000_0013 (NOP), state -> DONE, refill_err_o=1 with mem_comp_o.
REQ-024 bus_ack_i outside FETCH SHALL be ignored; no slot written.
REQ-025 Beat counter is 2 bits; wraps only by leaving FETCH, never re-fetches beat 0 within a refill.
REQ-026 mem_req_i dropping during FETCH SHALL NOT abort the refill; the line completes, DONE pulses, HOLD exits next cycle.

Reset
REQ-027 Reset SHALL force IDLE, beat=0, watchdog=0, line register=0, mem_data_o=0.
REQ-028 Outputs during/after reset: mem_comp_o=0, refill_err_o=0, busy_o=0, bus_req_o=0, bus_addr_o=0.
REQ-029 Reset mid-FETCH SHALL drop bus_req_o in the cycle after the reset edge; a late bus_ack_i is ignored.

Structure
REQ-030 Shared package icache_pkg SHALL hold the refill state enum, LINE_ADDR_W=8, WORD_ADDR_W=10, WORDS_PER_LINE=4 and RV_NOP=32'h0000_0013.
REQ-031 Watchdog counter SHALL be a sub-module icache_refill_wdog (clear, enable, expire output); all else in one module.

Verification
REQ-032 addr_mem_i=8'hA5, ack every cycle, rdata 11,22,33,44 -> bus_addr 294..297, mem_data_o=0x00000044_00000033_00000022_00000011, mem_comp_o at N+5.
REQ-033 Ack delayed 3 cycles on beat 2 -> bus_addr_o stable at beat 2 for 4 cycles, mem_comp_o at N+8, data correct.
REQ-034 TIMEOUT_CYC=8, no ack on beat 1 -> after 8 cycles slots 1..3 = 0x00000013, refill_err_o and mem_comp_o pulse together.
REQ-035 mem_req_i held high 4 cycles after mem_comp_o -> exactly one refill, busy_o low one cycle after mem_req_i falls.
REQ-036 reset asserted during beat 2 -> bus_req_o=0 next cycle, IDLE, mem_data_o=0, later request completes normally.
